mem_access_unit: RTL
====================

# mem_access_unit

Initiator side of the word-wide data memory port: takes load/store requests from the execute stage, drives the memory's address / write-data / write-strobe lines, captures read data after a fixed latency, and returns aligned, sign- or zero-extended results to writeback. Byte and halfword stores become read-modify-write, because the memory writes whole words only. Sits between the EX/MEM pipeline register and `data_memory`.

## Interface
- `DATA_W`, 32: data and address width in bits.
- `MEM_LATENCY`, 1: cycles from a read-enable cycle to valid `mem_read_data`. Legal range is 1–4.
- `clk`  in  1: the only clock. All logic is on its rising edge.
- `reset_n`  in  1: reset, synchronous and active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request. High only in IDLE.
- `req_op`  in  3: operation. LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=6, SH=7, SW=3.
- `req_addr`  in  DATA_W: byte address.
- `req_wdata`  in  DATA_W: store data, taken from its low bits.
- `req_rd`  in  5: destination tag, returned unchanged.
- `resp_valid`  out  1: response present.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_data`  out  DATA_W: load result. 0 for stores and errors.
- `resp_rd`  out  5: tag of the request being answered.
- `resp_err`  out  1: misaligned access.
- `mem_address`  out  DATA_W: word index, equal to `req_addr >> 2`.
- `mem_write_data`  out  DATA_W: word to write.
- `mem_control_write`  out  1: write strobe, high for exactly one cycle per store.
- `mem_read_en`  out  1: read strobe, high for one cycle.
- `mem_read_data`  in  DATA_W: read word, valid `MEM_LATENCY` cycles after `mem_read_en`.

## Operation
- Outputs are registered. After any edge with `reset_n`=0:
  - state is IDLE;
  - `req_ready`=1;
  - every other output is 0.
- A request is accepted on an edge where `req_valid && req_ready`. Op, address, data and tag are registered at that edge.
- FSM states and transitions:
  - IDLE → CHECK.
  - CHECK:
    - misaligned (LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0) → RESP with err=1, no memory access;
    - SW → WRITE;
    - any other op → READ.
  - READ: drives `mem_read_en` for one cycle, then WAIT.
  - WAIT: counts `MEM_LATENCY`, then samples `mem_read_data`.
    - Loads → RESP.
    - SB/SH → WRITE with the merged word.
  - WRITE: drives `mem_control_write` for one cycle → RESP.
  - RESP: holds `resp_valid` and all resp fields stable until `resp_ready`, then → IDLE.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], halfword h = bits [16h+15:16h].
- Load extension:
  - LB and LH sign-extend to DATA_W.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Store merge: the selected byte/halfword lane of the read word is replaced with `req_wdata[7:0]` / `[15:0]`; other lanes keep their read values. SW writes `req_wdata` whole.
- Outside their strobe cycles, `mem_address` and `mem_write_data` hold their last values; strobes are 0.
- Reset mid-operation drops the request with no response. A WRITE not yet issued never reaches memory.
- Opcode encoding 3'b011 is SW. No other encodings are free, so there is no illegal-op path.

## Timing
Request accepted at edge T, with `MEM_LATENCY`=L:
- Misaligned: `resp_valid` at T+2.
- SW: write strobe in cycle T+2; `resp_valid` at T+3.
- Loads: read strobe in cycle T+2; data sampled at T+2+L; `resp_valid` at T+3+L.
- SB/SH: read strobe at T+2; write strobe at T+3+L; `resp_valid` at T+4+L.
- The next request can be accepted on the edge after the `resp_valid && resp_ready` edge.
- Throughput is one request in flight; there is no overlap.

## Structure
- Shared package `mem_pkg`:
  - op encodings, as an enum;
  - FSM state enum;
  - byte-lane width constant;
  - `MEM_LATENCY` default.
- Sub-module `mem_lane_align` is purely combinational and holds both lane paths: load extract/extend (inputs: word, op, addr[1:0]) and store merge (inputs: word, wdata, op, addr[1:0]).

## Test plan
- Reset then SW addr 0x10, data 0xDEADBEEF → one write strobe with `mem_address`=4 and `mem_write_data`=0xDEADBEEF; response with err=0 and data=0; no read strobe.
- Memory word 4 = 0x80FF7F01:
  - LB 0x13 → 0xFFFFFF80;
  - LBU 0x13 → 0x00000080;
  - LH 0x10 → 0x00007F01;
  - LHU 0x12 → 0x000080FF;
  - LW 0x10 → 0x80FF7F01.
- Word 4 = 0x11223344, SB addr 0x11 data 0xAB → read strobe, then write strobe with 0x1122AB44. Same word, SH 0x12 data 0xBEEF → write of 0xBEEF3344.
- LH 0x11 and SW 0x12 → `resp_err`=1 two cycles after accept; neither strobe ever asserts.
- `resp_ready` held low 5 cycles with LW pending → resp fields stable and `req_ready`=0 throughout; accept on the cycle after the handshake.
- `reset_n` low during WAIT of an SB → no write strobe and no response; `req_ready`=1 after the reset edge. Repeat the load-timing checks with `MEM_LATENCY`=3.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory initiator: op encodings,
// FSM states and small decode helpers used by the unit and its lane logic.
package mem_pkg;

    localparam int BYTE_W              = 8;
    localparam int MEM_LATENCY_DEFAULT = 1;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_SW  = 3'd3,
        OP_LBU = 3'd4,
        OP_LHU = 3'd5,
        OP_SB  = 3'd6,
        OP_SH  = 3'd7
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } mau_state_e;

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            OP_LW, OP_SW:         return |addr_lo;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte/halfword lane handling: load extract with sign/zero
// extension, and store merge of a sub-word into the word read from memory.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  mem_op_e           op,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] store_word
);

    logic [BYTE_W-1:0]   byte_v;
    logic [2*BYTE_W-1:0] half_v;
    logic [DATA_W-1:0]   lane_mask;
    logic [DATA_W-1:0]   lane_data;

    always_comb begin
        byte_v = word[addr_lo*BYTE_W +: BYTE_W];
        half_v = word[{addr_lo[1], 1'b0}*BYTE_W +: 2*BYTE_W];

        case (op)
            OP_LB:   load_data = {{(DATA_W-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
            OP_LBU:  load_data = {{(DATA_W-BYTE_W){1'b0}}, byte_v};
            OP_LH:   load_data = {{(DATA_W-2*BYTE_W){half_v[2*BYTE_W-1]}}, half_v};
            OP_LHU:  load_data = {{(DATA_W-2*BYTE_W){1'b0}}, half_v};
            default: load_data = word;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the read word is kept.
    always_comb begin
        lane_mask = '0;
        lane_data = '0;
        case (op)
            OP_SB: begin
                lane_mask[addr_lo*BYTE_W +: BYTE_W] = '1;
                lane_data[addr_lo*BYTE_W +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            OP_SH: begin
                lane_mask[{addr_lo[1], 1'b0}*BYTE_W +: 2*BYTE_W] = '1;
                lane_data[{addr_lo[1], 1'b0}*BYTE_W +: 2*BYTE_W] = wdata[2*BYTE_W-1:0];
            end
            default: ;
        endcase
        store_word = (op == OP_SW) ? wdata : ((word & ~lane_mask) | lane_data);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-wide data memory: one request in flight,
// registered outputs, read-modify-write for byte and halfword stores.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_control_write,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

    mau_state_e        state_q, state_d;
    mem_op_e           op_q, op_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
    logic              mem_control_write_q, mem_control_write_d;
    logic              mem_read_en_q, mem_read_en_d;

    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;

    mem_lane_align #(
        .DATA_W(DATA_W)
    ) u_lane_align (
        .word      (mem_read_data),
        .op        (op_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_word(store_word)
    );

    // Outputs are registered, so each transition loads the value the
    // destination state must present during its first cycle.
    always_comb begin
        state_d             = state_q;
        op_d                = op_q;
        addr_d              = addr_q;
        wdata_d             = wdata_q;
        rd_d                = rd_q;
        wait_cnt_d          = wait_cnt_q;
        req_ready_d         = req_ready_q;
        resp_valid_d        = resp_valid_q;
        resp_data_d         = resp_data_q;
        resp_rd_d           = resp_rd_q;
        resp_err_d          = resp_err_q;
        mem_address_d       = mem_address_q;
        mem_write_data_d    = mem_write_data_q;
        mem_control_write_d = 1'b0;
        mem_read_en_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = mem_op_e'(req_op);
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rd_d        = req_rd;
                    req_ready_d = 1'b0;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (is_misaligned(op_q, addr_q[1:0])) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '0;
                    resp_rd_d    = rd_q;
                end else begin
                    mem_address_d = addr_q >> 2;
                    if (op_q == OP_SW) begin
                        state_d             = ST_WRITE;
                        mem_control_write_d = 1'b1;
                        mem_write_data_d    = wdata_q;
                    end else begin
                        state_d       = ST_READ;
                        mem_read_en_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                if (wait_cnt_q == LAT_LAST) begin
                    if (is_store(op_q)) begin
                        state_d             = ST_WRITE;
                        mem_control_write_d = 1'b1;
                        mem_write_data_d    = store_word;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_data_d  = load_data;
                        resp_rd_d    = rd_q;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_data_d  = '0;
                resp_rd_d    = rd_q;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q             <= ST_IDLE;
            op_q                <= OP_LB;
            addr_q              <= '0;
            wdata_q             <= '0;
            rd_q                <= '0;
            wait_cnt_q          <= '0;
            req_ready_q         <= 1'b1;
            resp_valid_q        <= 1'b0;
            resp_data_q         <= '0;
            resp_rd_q           <= '0;
            resp_err_q          <= 1'b0;
            mem_address_q       <= '0;
            mem_write_data_q    <= '0;
            mem_control_write_q <= 1'b0;
            mem_read_en_q       <= 1'b0;
        end else begin
            state_q             <= state_d;
            op_q                <= op_d;
            addr_q              <= addr_d;
            wdata_q             <= wdata_d;
            rd_q                <= rd_d;
            wait_cnt_q          <= wait_cnt_d;
            req_ready_q         <= req_ready_d;
            resp_valid_q        <= resp_valid_d;
            resp_data_q         <= resp_data_d;
            resp_rd_q           <= resp_rd_d;
            resp_err_q          <= resp_err_d;
            mem_address_q       <= mem_address_d;
            mem_write_data_q    <= mem_write_data_d;
            mem_control_write_q <= mem_control_write_d;
            mem_read_en_q       <= mem_read_en_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign resp_valid        = resp_valid_q;
    assign resp_data         = resp_data_q;
    assign resp_rd           = resp_rd_q;
    assign resp_err          = resp_err_q;
    assign mem_address       = mem_address_q;
    assign mem_write_data    = mem_write_data_q;
    assign mem_control_write = mem_control_write_q;
    assign mem_read_en       = mem_read_en_q;

endmodule
